// File: rtl/msg_send_queue.sv
// Buffers producer messages in a small FIFO and paces them onto the clock-domain
// channel's trigger/msg pins, leaving a fixed holdoff after every send.
module msg_send_queue #(
  parameter int MsgLen  = 8,
  parameter int Depth   = 4,
  parameter int Holdoff = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_trigger,
  input  logic [MsgLen-1:0]        push_msg,
  output logic                     push_full,
  output logic                     push_drop,
  output logic [7:0]               drop_count,
  output logic [$clog2(Depth):0]   pending,
  output logic                     ch_trigger,
  output logic [MsgLen-1:0]        ch_msg
);

  localparam int PW = $clog2(Depth);
  localparam int CW = (Holdoff > 1) ? $clog2(Holdoff) : 1;
  localparam logic [PW:0]   FULL     = (PW+1)'(Depth);
  localparam logic [CW-1:0] HOLD_CNT = CW'(Holdoff - 1);

  typedef enum logic [0:0] {IDLE, HOLD} state_t;

  state_t                         state_q, state_d;
  logic [Depth-1:0][MsgLen-1:0]   mem_q, mem_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]                    pending_q, pending_d;
  logic                           push_full_q, push_full_d;
  logic                           push_drop_q, push_drop_d;
  logic [7:0]                     drop_count_q, drop_count_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           ch_trigger_q, ch_trigger_d;
  logic [MsgLen-1:0]              ch_msg_q, ch_msg_d;
  logic                           pop, push_ok;

  // A pop frees the head slot in the same edge, so a push into a full FIFO
  // is still accepted on a send cycle.
  assign pop     = (state_q == IDLE) && (pending_q != '0);
  assign push_ok = push_trigger && ((pending_q < FULL) || pop);

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pending_d    = pending_q;
    drop_count_d = drop_count_q;
    push_drop_d  = push_trigger && !push_ok;
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_trigger_d = 1'b0;
    ch_msg_d     = ch_msg_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_msg;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (push_drop_d && (drop_count_q != 8'hFF))
      drop_count_d = drop_count_q + 8'd1;

    case ({push_ok, pop})
      2'b10:   pending_d = pending_q + (PW+1)'(1);
      2'b01:   pending_d = pending_q - (PW+1)'(1);
      default: pending_d = pending_q;
    endcase
    push_full_d = (pending_d == FULL);

    case (state_q)
      IDLE: begin
        if (pop) begin
          ch_trigger_d = 1'b1;
          ch_msg_d     = mem_q[rd_ptr_q];
          rd_ptr_d     = rd_ptr_q + PW'(1);
          cnt_d        = HOLD_CNT;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pending_q    <= '0;
      push_full_q  <= 1'b0;
      push_drop_q  <= 1'b0;
      drop_count_q <= '0;
      cnt_q        <= '0;
      ch_trigger_q <= 1'b0;
      ch_msg_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pending_q    <= pending_d;
      push_full_q  <= push_full_d;
      push_drop_q  <= push_drop_d;
      drop_count_q <= drop_count_d;
      cnt_q        <= cnt_d;
      ch_trigger_q <= ch_trigger_d;
      ch_msg_q     <= ch_msg_d;
    end
  end

  assign push_full  = push_full_q;
  assign push_drop  = push_drop_q;
  assign drop_count = drop_count_q;
  assign pending    = pending_q;
  assign ch_trigger = ch_trigger_q;
  assign ch_msg     = ch_msg_q;

endmodule

// File: tb/tb_msg_send_queue.sv
// Directed bench: stimulus pushes expected messages into a scoreboard queue,
// a negedge monitor pops and checks each channel send plus pacing.
module tb_msg_send_queue;

  localparam int MsgLen  = 8;
  localparam int Depth   = 4;
  localparam int Holdoff = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push_trigger = 1'b0;
  logic [MsgLen-1:0] push_msg = '0;
  logic              push_full, push_drop, ch_trigger;
  logic [7:0]        drop_count;
  logic [2:0]        pending;
  logic [MsgLen-1:0] ch_msg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drop_pulses = 0;
  int last_trig = -1;
  logic [MsgLen-1:0] last_msg = '0;
  logic [MsgLen-1:0] exp_q[$];
  int trig_t[$];

  msg_send_queue #(.MsgLen(MsgLen), .Depth(Depth), .Holdoff(Holdoff)) dut (
    .clk(clk), .rst_n(rst_n), .push_trigger(push_trigger), .push_msg(push_msg),
    .push_full(push_full), .push_drop(push_drop), .drop_count(drop_count),
    .pending(pending), .ch_trigger(ch_trigger), .ch_msg(ch_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: message order, spacing between sends, ch_msg stability.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_msg  = '0;
      last_trig = -1;
    end else begin
      if (push_drop) drop_pulses++;
      if (ch_trigger) begin
        trig_t.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_send", int'(ch_msg), -1);
        else chk("send_msg", int'(ch_msg), int'(exp_q.pop_front()));
        if (last_trig >= 0) begin
          checks++;
          if (cyc - last_trig < Holdoff + 1) begin
            failures++;
            $display("FAIL send_gap: got %0d cycles expected >= %0d", cyc - last_trig, Holdoff + 1);
          end
        end
        last_trig = cyc;
        last_msg  = ch_msg;
      end else if (ch_msg != last_msg) begin
        chk("ch_msg_stable", int'(ch_msg), int'(last_msg));
        last_msg = ch_msg;
      end
    end
  end

  task automatic push(input logic [MsgLen-1:0] m);
    push_trigger = 1'b1;
    push_msg     = m;
    @(negedge clk);
    push_trigger = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_full", push_full, 0);
    chk("rst_drop", push_drop, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_trigger", ch_trigger, 0);
    chk("rst_msg", ch_msg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single message: send one cycle after the push edge.
    exp_q.push_back(8'hA5);
    push(8'hA5);
    chk("a5_pending_after_push", pending, 1);
    chk("a5_no_bypass", ch_trigger, 0);
    @(negedge clk);
    chk("a5_trigger", ch_trigger, 1);
    chk("a5_msg", ch_msg, 8'hA5);
    chk("a5_pending_after_pop", pending, 0);
    idle(20);

    // Three back-to-back pushes: sends exactly Holdoff+1 apart.
    trig_t.delete();
    foreach (exp_q[i]) chk("queue_drained_1", 1, 0);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    push(8'h01); push(8'h02); push(8'h03);
    idle(25);
    #1;
    chk("three_sends", trig_t.size(), 3);
    if (trig_t.size() == 3) begin
      chk("gap_1_2", trig_t[1] - trig_t[0], Holdoff + 1);
      chk("gap_2_3", trig_t[2] - trig_t[1], Holdoff + 1);
    end
    idle(10);

    // Overflow while in HOLD: 4 queued, 2 dropped.
    exp_q.push_back(8'h20);
    push(8'h20);
    @(negedge clk);
    chk("hold_entry_trigger", ch_trigger, 1);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    push(8'h31); push(8'h32); push(8'h33);
    push(8'h34); push(8'h35); push(8'h36);
    chk("ovf_pending", pending, 4);
    chk("ovf_full", push_full, 1);
    chk("ovf_drop_count", drop_count, 2);
    chk("ovf_drop_pulse_last", push_drop, 1);

    // Push lands on the edge that pops the head of a full FIFO.
    idle(2);
    exp_q.push_back(8'h37);
    push(8'h37);
    chk("popfull_trigger", ch_trigger, 1);
    chk("popfull_msg", ch_msg, 8'h31);
    chk("popfull_no_drop", push_drop, 0);
    chk("popfull_pending", pending, 4);
    chk("popfull_full", push_full, 1);
    chk("popfull_drop_count", drop_count, 2);
    idle(50);
    chk("drop_pulses", drop_pulses, 2);
    chk("drained_2", exp_q.size(), 0);
    chk("drained_pending", pending, 0);
    chk("drained_full", push_full, 0);

    // Reset in HOLD with 3 pending: everything clears, nothing else sent.
    exp_q.push_back(8'h41);
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    chk("pre_rst_pending", pending, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_full", push_full, 0);
    chk("mid_rst_drop", push_drop, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    chk("mid_rst_trigger", ch_trigger, 0);
    chk("mid_rst_msg", ch_msg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    trig_t.delete();
    idle(40);
    #1;
    chk("post_rst_sends", trig_t.size(), 0);
    chk("post_rst_queue", exp_q.size(), 0);
    chk("post_rst_pending", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
